// File: rtl/field_update_seq.sv
// -----------------------------------------------------------------------------
// field_update_seq
//
// Command sequencer sitting directly upstream of ReadWriteField. Accepts one
// field operation (RD, WR, or read-modify-write ADD) on a 2*TGT_BITS hITEM
// binary, drives the fieldGo/wryt/fieldNum/fieldIn pulse sequence that
// ReadWriteField expects, captures its outputs and returns the updated
// structure plus the old field value over a valid/ready response port.
//
// Build option:
//   FIELD_SEQ_SATURATE_EN  defined   -> out-of-range ADD clamps to 0 / 2^W-1
//                          undefined -> out-of-range ADD wraps modulo 2^W
//   rspErr flags an out-of-range ADD in both builds.
//
// Ports:
//   clk, rsta                      clock (rising edge), sync active-high reset
//   cmdValid/cmdReady              command handshake
//   cmdOp, cmdField                0=RD 1=WR 2=ADD 3=reserved; field selector
//   cmdStruct, cmdValue            input structure; WR data or signed ADD delta
//   rspValid/rspReady              response handshake (held until accepted)
//   rspStruct, rspField, rspErr    result structure, pre-op field value, error
//   fieldGo, wryt, fieldNum        control to ReadWriteField
//   structToRwf, fieldToRwf        data to ReadWriteField
//   structFromRwf, fieldFromRwf    data from ReadWriteField
// -----------------------------------------------------------------------------
module field_update_seq #(
   parameter int TGT_BITS    = 64,
   parameter int HCOUNT_BITS = 12,
   parameter int TOTAL_BITS  = 40
) (
   input  logic                  clk,
   input  logic                  rsta,
   input  logic                  cmdValid,
   output logic                  cmdReady,
   input  logic [1:0]            cmdOp,
   input  logic [3:0]            cmdField,
   input  logic [2*TGT_BITS-1:0] cmdStruct,
   input  logic [TGT_BITS-1:0]   cmdValue,
   output logic                  rspValid,
   input  logic                  rspReady,
   output logic [2*TGT_BITS-1:0] rspStruct,
   output logic [TGT_BITS-1:0]   rspField,
   output logic                  rspErr,
   output logic                  fieldGo,
   output logic                  wryt,
   output logic [3:0]            fieldNum,
   output logic [2*TGT_BITS-1:0] structToRwf,
   output logic [TGT_BITS-1:0]   fieldToRwf,
   input  logic [2*TGT_BITS-1:0] structFromRwf,
   input  logic [TGT_BITS-1:0]   fieldFromRwf
);

   typedef enum logic [1:0] {OP_RD, OP_WR, OP_ADD, OP_RSVD} op_e;
   typedef enum logic [3:0] {FLD_DATA, FLD_STOP, FLD_P1, FLD_P2, FLD_COUNT, FLD_TOTAL} field_e;
   typedef enum logic [2:0] {S_IDLE, S_RD_GO, S_RD_CAP, S_WR_GO, S_WR_HOLD, S_WR_CAP, S_RSP} state_e;

   localparam logic [TGT_BITS:0] MAX_COUNT = {{(TGT_BITS+1-HCOUNT_BITS){1'b0}}, {HCOUNT_BITS{1'b1}}};
   localparam logic [TGT_BITS:0] MAX_TOTAL = {{(TGT_BITS+1-TOTAL_BITS){1'b0}}, {TOTAL_BITS{1'b1}}};

   state_e                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [3:0]            field_q, field_d;
   logic [2*TGT_BITS-1:0] struct_q, struct_d;
   logic [TGT_BITS-1:0]   cmd_value_q, cmd_value_d;
   logic [TGT_BITS-1:0]   wr_value_q, wr_value_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [2*TGT_BITS-1:0] rsp_struct_q, rsp_struct_d;
   logic [TGT_BITS-1:0]   rsp_field_q, rsp_field_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [TGT_BITS:0]     add_sum;
   logic [TGT_BITS:0]     add_max;
   logic                  add_under;
   logic                  add_over;
   logic [TGT_BITS-1:0]   add_result;
   logic                  add_legal;

   // ADD arithmetic: zero-extended old value plus sign-extended delta. The old
   // value from ReadWriteField never exceeds 2^W-1, so one extra bit suffices;
   // a set top bit means the sum went negative.
   always_comb begin
      add_sum   = {1'b0, fieldFromRwf} + {cmd_value_q[TGT_BITS-1], cmd_value_q};
      add_max   = (field_q == FLD_TOTAL) ? MAX_TOTAL : MAX_COUNT;
      add_under = add_sum[TGT_BITS];
      add_over  = !add_under && (add_sum > add_max);
`ifdef FIELD_SEQ_SATURATE_EN
      if (add_under)     add_result = '0;
      else if (add_over) add_result = add_max[TGT_BITS-1:0];
      else               add_result = add_sum[TGT_BITS-1:0];
`else
      add_result = add_sum[TGT_BITS-1:0] & add_max[TGT_BITS-1:0];
`endif
   end

   // Only COUNT and TOTAL are numeric; op 3 is always rejected.
   assign add_legal = (cmdOp == OP_ADD) && ((cmdField == FLD_COUNT) || (cmdField == FLD_TOTAL));

   // Ready is masked by rsta so it reads 0 for every cycle reset is held.
   assign cmdReady = (state_q == S_IDLE) && !rsta;

   always_comb begin
      // NOTE: every _d is given its hold value first, so no path through the
      // case below leaves a signal unassigned and no latch is inferred.
      state_d      = state_q;
      op_d         = op_q;
      field_d      = field_q;
      struct_d     = struct_q;
      cmd_value_d  = cmd_value_q;
      wr_value_d   = wr_value_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_struct_d = rsp_struct_q;
      rsp_field_d  = rsp_field_q;
      rsp_err_d    = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (cmdValid && cmdReady) begin
               op_d        = cmdOp;
               field_d     = cmdField;
               struct_d    = cmdStruct;
               cmd_value_d = cmdValue;
               wr_value_d  = cmdValue;
               rsp_field_d = '0;
               rsp_err_d   = 1'b0;
               if (cmdOp == OP_RD || add_legal) begin
                  state_d = S_RD_GO;
               end else if (cmdOp == OP_WR) begin
                  state_d = S_WR_GO;
               end else begin
                  rsp_struct_d = cmdStruct;
                  rsp_err_d    = 1'b1;
                  state_d      = S_RSP;
               end
            end
         end
         S_RD_GO: state_d = S_RD_CAP;
         S_RD_CAP: begin
            rsp_field_d = fieldFromRwf;
            if (op_q == OP_RD) begin
               rsp_struct_d = struct_q;
               state_d      = S_RSP;
            end else begin
               wr_value_d = add_result;
               rsp_err_d  = add_under || add_over;
               state_d    = S_WR_GO;
            end
         end
         S_WR_GO:   state_d = S_WR_HOLD;
         S_WR_HOLD: state_d = S_WR_CAP;
         S_WR_CAP: begin
            rsp_struct_d = structFromRwf;
            state_d      = S_RSP;
         end
         S_RSP: begin
            // rspValid rises one cycle after entering RSP, so response data
            // has settled in its registers before it is offered.
            rsp_valid_d = 1'b1;
            if (rsp_valid_q && rspReady) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge value
   // of every other flop regardless of statement order.
   always_ff @(posedge clk) begin
      if (rsta) begin
         // NOTE: the datapath registers are reset as well because every
         // output, including the data buses, must read 0 after reset.
         state_q      <= S_IDLE;
         op_q         <= '0;
         field_q      <= '0;
         struct_q     <= '0;
         cmd_value_q  <= '0;
         wr_value_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_struct_q <= '0;
         rsp_field_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         field_q      <= field_d;
         struct_q     <= struct_d;
         cmd_value_q  <= cmd_value_d;
         wr_value_q   <= wr_value_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_struct_q <= rsp_struct_d;
         rsp_field_q  <= rsp_field_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // fieldGo only in the single-cycle *_GO states, so it never pulses twice
   // in a row; wryt stays up through WR_HOLD while the field is applied.
   assign fieldGo     = (state_q == S_RD_GO) || (state_q == S_WR_GO);
   assign wryt        = (state_q == S_WR_GO) || (state_q == S_WR_HOLD);
   assign fieldNum    = field_q;
   assign structToRwf = struct_q;
   assign fieldToRwf  = wr_value_q;

   assign rspValid  = rsp_valid_q;
   assign rspStruct = rsp_struct_q;
   assign rspField  = rsp_field_q;
   assign rspErr    = rsp_err_q;

endmodule

// File: tb/tb_field_update_seq.sv
// -----------------------------------------------------------------------------
// tb_field_update_seq
//
// Self-checking bench for field_update_seq. A small behavioural ReadWriteField
// stands in for the downstream block, using this hITEM layout:
//   [7:0] data, [31:8] p1, [39:32] p1_hi, [63:40] p2, [71:64] p2_hi,
//   [72] stop, [84:73] count (12 bits), [127:88] total (40 bits).
// P1/P2 are exchanged as byte addresses {hi, word, 8'h00}.
// Expected results come from a reference model computed with plain signed
// arithmetic on the field values.
// -----------------------------------------------------------------------------
module tb_field_update_seq;

   logic         clk = 1'b0;
   logic         rsta;
   logic         cmdValid;
   logic         cmdReady;
   logic [1:0]   cmdOp;
   logic [3:0]   cmdField;
   logic [127:0] cmdStruct;
   logic [63:0]  cmdValue;
   logic         rspValid;
   logic         rspReady;
   logic [127:0] rspStruct;
   logic [63:0]  rspField;
   logic         rspErr;
   logic         fieldGo;
   logic         wryt;
   logic [3:0]   fieldNum;
   logic [127:0] structToRwf;
   logic [63:0]  fieldToRwf;
   logic [127:0] structFromRwf;
   logic [63:0]  fieldFromRwf;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   field_update_seq #(.TGT_BITS(64), .HCOUNT_BITS(12), .TOTAL_BITS(40)) dut (
      .clk(clk), .rsta(rsta),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdField(cmdField),
      .cmdStruct(cmdStruct), .cmdValue(cmdValue),
      .rspValid(rspValid), .rspReady(rspReady), .rspStruct(rspStruct),
      .rspField(rspField), .rspErr(rspErr),
      .fieldGo(fieldGo), .wryt(wryt), .fieldNum(fieldNum),
      .structToRwf(structToRwf), .fieldToRwf(fieldToRwf),
      .structFromRwf(structFromRwf), .fieldFromRwf(fieldFromRwf)
   );

   // ---------------- ReadWriteField stand-in ----------------
   function automatic logic [63:0] rwf_read(input logic [127:0] s, input logic [3:0] f);
      case (f)
         4'd0:    rwf_read = {56'd0, s[7:0]};
         4'd1:    rwf_read = {63'd0, s[72]};
         4'd2:    rwf_read = {24'd0, s[39:32], s[31:8], 8'h00};
         4'd3:    rwf_read = {24'd0, s[71:64], s[63:40], 8'h00};
         4'd4:    rwf_read = {52'd0, s[84:73]};
         4'd5:    rwf_read = {24'd0, s[127:88]};
         default: rwf_read = '0;
      endcase
   endfunction

   function automatic logic [127:0] rwf_write(input logic [127:0] s, input logic [3:0] f,
                                              input logic [63:0] v);
      logic [127:0] r;
      r = s;
      case (f)
         4'd0:    r[7:0]    = v[7:0];
         4'd1:    r[72]     = v[0];
         4'd2:    r[39:8]   = v[39:8];
         4'd3:    r[71:40]  = v[39:8];
         4'd4:    r[84:73]  = v[11:0];
         4'd5:    r[127:88] = v[39:0];
         default: r = s;
      endcase
      return r;
   endfunction

   // Read data appears the cycle after the read pulse; a write applies the
   // field during the hold cycle after the write pulse and the new structure
   // is visible in the cycle after that.
   logic rwf_wr_pend;
   always @(posedge clk) begin
      if (rsta) begin
         rwf_wr_pend   <= 1'b0;
         fieldFromRwf  <= '0;
         structFromRwf <= '0;
      end else begin
         if (fieldGo && !wryt) fieldFromRwf <= rwf_read(structToRwf, fieldNum);
         if (rwf_wr_pend) structFromRwf <= rwf_write(structToRwf, fieldNum, fieldToRwf);
         rwf_wr_pend <= fieldGo && wryt;
      end
   end

   // ---------------- reference model ----------------
   task automatic model_op(input logic [1:0] op, input logic [3:0] f, input logic [127:0] s,
                           input logic [63:0] v, output logic [127:0] es, output logic [63:0] ef,
                           output logic ee, output int elat, output int egr, output int egw);
      logic signed [67:0] sum;
      logic signed [67:0] lim;
      logic [63:0]        old;
      logic [63:0]        res;
      es = s; ef = '0; ee = 1'b0; egr = 0; egw = 0; elat = 1;
      if (op == 2'd0) begin
         ef = rwf_read(s, f); elat = 3; egr = 1;
      end else if (op == 2'd1) begin
         es = rwf_write(s, f, v); elat = 4; egw = 1;
      end else if (op == 2'd2 && (f == 4'd4 || f == 4'd5)) begin
         lim = (f == 4'd4) ? 68'sd4095 : 68'sd1099511627775;
         old = rwf_read(s, f);
         sum = $signed({4'b0000, old}) + $signed({{4{v[63]}}, v});
         ee  = (sum < 0) || (sum > lim);
`ifdef FIELD_SEQ_SATURATE_EN
         if (sum < 0)        res = '0;
         else if (sum > lim) res = lim[63:0];
         else                res = sum[63:0];
`else
         res = sum[63:0] & lim[63:0];   // two's complement: modulo 2^W
`endif
         ef = old; es = rwf_write(s, f, res); elat = 6; egr = 1; egw = 1;
      end else begin
         ee = 1'b1; elat = 1;
      end
   endtask

   // ---------------- command driver / observer ----------------
   logic [127:0] o_struct;
   logic [63:0]  o_field;
   logic         o_err;
   int           o_lat, o_go_rd, o_go_wr;
   logic         o_proto_ok, o_stable_ok;

   // Issues one command from a negedge, watches the ReadWriteField pulses,
   // records the response and completes the handshake after bp stall cycles.
   task automatic do_cmd(input logic [1:0] op, input logic [3:0] f, input logic [127:0] s,
                         input logic [63:0] v, input int bp);
      logic        prev_go, chk_hold;
      logic [63:0] hold_v;
      logic [3:0]  hold_f;
      int          k;
      o_proto_ok = 1'b1; o_stable_ok = 1'b1; o_go_rd = 0; o_go_wr = 0; o_lat = -1;
      o_struct = '0; o_field = '0; o_err = 1'b0;
      k = 0;
      while (cmdReady !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      if (cmdReady !== 1'b1) o_proto_ok = 1'b0;
      cmdValid = 1'b1; cmdOp = op; cmdField = f; cmdStruct = s; cmdValue = v;
      @(posedge clk);
      prev_go = 1'b0; chk_hold = 1'b0; hold_v = '0; hold_f = '0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         cmdValid  = 1'b0;
         cmdStruct = {$urandom, $urandom, $urandom, $urandom};
         cmdValue  = {$urandom, $urandom};
         if (cmdReady !== 1'b0) o_proto_ok = 1'b0;
         if (chk_hold && (fieldToRwf !== hold_v || fieldNum !== hold_f)) o_proto_ok = 1'b0;
         chk_hold = 1'b0;
         if (fieldGo === 1'b1) begin
            if (prev_go || fieldNum !== f || structToRwf !== s) o_proto_ok = 1'b0;
            if (wryt === 1'b1) begin
               o_go_wr++; hold_v = fieldToRwf; hold_f = fieldNum; chk_hold = 1'b1;
            end else begin
               o_go_rd++;
            end
         end
         prev_go = (fieldGo === 1'b1);
         if (rspValid === 1'b1) begin
            o_lat = k;
            break;
         end
      end
      if (o_lat < 0) return;
      o_struct = rspStruct; o_field = rspField; o_err = rspErr;
      for (int b = 0; b < bp; b++) begin
         @(negedge clk);
         if (rspValid !== 1'b1 || rspStruct !== o_struct || rspField !== o_field ||
             rspErr !== o_err || cmdReady !== 1'b0) o_stable_ok = 1'b0;
      end
      rspReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rspReady = 1'b0;
      if (rspValid !== 1'b0 || cmdReady !== 1'b1) o_proto_ok = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rsta = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cmdReady, fieldGo, wryt, rspValid, rspErr} !== 5'b0)
         $display("FAIL reset_ctrl: got %b want 00000", {cmdReady, fieldGo, wryt, rspValid, rspErr});
      else n_pass++;
      n_checks++;
      if ({fieldNum, structToRwf, fieldToRwf, rspStruct, rspField} !== '0)
         $display("FAIL reset_data: got nonzero fieldNum=%h rspField=%h", fieldNum, rspField);
      else n_pass++;
      rsta = 1'b0;
      #1;
      n_checks++;
      if (cmdReady !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmdReady);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_rd_p1();
      logic [127:0] s;
      s = '0; s[31:8] = 24'h345678; s[39:32] = 8'h12;
      do_cmd(2'd0, 4'd2, s, {$urandom, $urandom}, 0);
      n_checks++;
      if (o_field !== 64'h12_3456_7800) $display("FAIL rd_p1_field: got %h want 1234567800", o_field);
      else n_pass++;
      n_checks++;
      if (o_struct !== s) $display("FAIL rd_p1_struct: got %h want %h", o_struct, s);
      else n_pass++;
      n_checks++;
      if (o_lat != 3) $display("FAIL rd_p1_latency: got %0d want 3", o_lat);
      else n_pass++;
      n_checks++;
      if (o_go_rd != 1 || o_go_wr != 0 || !o_proto_ok)
         $display("FAIL rd_p1_pulses: got rd=%0d wr=%0d proto=%b want rd=1 wr=0 proto=1", o_go_rd, o_go_wr, o_proto_ok);
      else n_pass++;
   endtask

   task automatic test_wr_stop();
      logic [127:0] exp_s;
      exp_s = '0; exp_s[72] = 1'b1;
      do_cmd(2'd1, 4'd1, '0, 64'd1, 0);
      n_checks++;
      if (o_struct !== exp_s) $display("FAIL wr_stop_struct: got %h want %h", o_struct, exp_s);
      else n_pass++;
      n_checks++;
      if (o_field !== 64'd0 || o_err !== 1'b0) $display("FAIL wr_stop_field_err: got %h/%b want 0/0", o_field, o_err);
      else n_pass++;
      n_checks++;
      if (o_lat != 4) $display("FAIL wr_stop_latency: got %0d want 4", o_lat);
      else n_pass++;
      n_checks++;
      if (o_go_rd != 0 || o_go_wr != 1 || !o_proto_ok)
         $display("FAIL wr_stop_pulses_hold: got rd=%0d wr=%0d proto=%b want rd=0 wr=1 proto=1", o_go_rd, o_go_wr, o_proto_ok);
      else n_pass++;
   endtask

   task automatic test_add_count();
      logic [127:0] s, exp_s;
      s = {$urandom, $urandom, $urandom, $urandom}; s[84:73] = 12'd5;
      do_cmd(2'd2, 4'd4, s, 64'd3, 1);
      exp_s = s; exp_s[84:73] = 12'd8;
      n_checks++;
      if (o_struct !== exp_s) $display("FAIL add_count_inc_struct: got %h want %h", o_struct, exp_s);
      else n_pass++;
      n_checks++;
      if (o_field !== 64'd5 || o_err !== 1'b0) $display("FAIL add_count_inc_field_err: got %h/%b want 5/0", o_field, o_err);
      else n_pass++;
      n_checks++;
      if (o_lat != 6 || o_go_rd != 1 || o_go_wr != 1 || !o_proto_ok)
         $display("FAIL add_count_inc_timing: got lat=%0d rd=%0d wr=%0d proto=%b want 6/1/1/1", o_lat, o_go_rd, o_go_wr, o_proto_ok);
      else n_pass++;
      do_cmd(2'd2, 4'd4, s, -64'sd7, 0);
      exp_s = s;
`ifdef FIELD_SEQ_SATURATE_EN
      exp_s[84:73] = 12'd0;
`else
      exp_s[84:73] = 12'hFFE;
`endif
      n_checks++;
      if (o_struct !== exp_s) $display("FAIL add_count_under_struct: got %h want %h", o_struct, exp_s);
      else n_pass++;
      n_checks++;
      if (o_err !== 1'b1 || o_field !== 64'd5) $display("FAIL add_count_under_err: got %b/%h want 1/5", o_err, o_field);
      else n_pass++;
   endtask

   task automatic test_add_total();
      logic [127:0] s, exp_s;
      s = {$urandom, $urandom, $urandom, $urandom}; s[127:88] = 40'hFF_FFFF_FFFE;
      do_cmd(2'd2, 4'd5, s, 64'd5, 2);
      exp_s = s;
`ifdef FIELD_SEQ_SATURATE_EN
      exp_s[127:88] = 40'hFF_FFFF_FFFF;
`else
      exp_s[127:88] = 40'h00_0000_0003;
`endif
      n_checks++;
      if (o_struct !== exp_s) $display("FAIL add_total_over_struct: got %h want %h", o_struct, exp_s);
      else n_pass++;
      n_checks++;
      if (o_err !== 1'b1 || o_field !== 64'hFF_FFFF_FFFE) $display("FAIL add_total_over_err: got %b/%h want 1/fffffffffe", o_err, o_field);
      else n_pass++;
      n_checks++;
      if (!o_stable_ok) $display("FAIL add_total_backpressure: got unstable want stable");
      else n_pass++;
   endtask

   task automatic test_illegal_backpressure();
      logic [127:0] s;
      s = {$urandom, $urandom, $urandom, $urandom};
      do_cmd(2'd2, 4'd0, s, 64'd9, 5);
      n_checks++;
      if (o_go_rd != 0 || o_go_wr != 0) $display("FAIL illegal_no_go: got rd=%0d wr=%0d want 0/0", o_go_rd, o_go_wr);
      else n_pass++;
      n_checks++;
      if (o_err !== 1'b1 || o_field !== 64'd0 || o_struct !== s)
         $display("FAIL illegal_rsp: got err=%b field=%h struct=%h want 1/0/%h", o_err, o_field, o_struct, s);
      else n_pass++;
      n_checks++;
      if (o_lat != 1) $display("FAIL illegal_latency: got %0d want 1", o_lat);
      else n_pass++;
      n_checks++;
      if (!o_stable_ok || !o_proto_ok) $display("FAIL illegal_backpressure: got stable=%b proto=%b want 1/1", o_stable_ok, o_proto_ok);
      else n_pass++;
      do_cmd(2'd3, 4'd4, s, 64'd1, 0);
      n_checks++;
      if (o_err !== 1'b1 || o_lat != 1 || o_go_rd != 0) $display("FAIL op3_rejected: got err=%b lat=%0d rd=%0d want 1/1/0", o_err, o_lat, o_go_rd);
      else n_pass++;
   endtask

   task automatic test_reset_midop();
      logic [127:0] s, exp_s;
      logic         seen, got_rsp;
      s = {$urandom, $urandom, $urandom, $urandom}; s[84:73] = 12'd100;
      cmdValid = 1'b1; cmdOp = 2'd2; cmdField = 4'd4; cmdStruct = s; cmdValue = 64'd20;
      @(posedge clk);
      @(negedge clk);
      cmdValid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (fieldGo === 1'b1 && wryt === 1'b1) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!seen) $display("FAIL midop_wr_go: got no write pulse want one");
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (fieldGo !== 1'b0 || fieldToRwf !== 64'd120) $display("FAIL midop_hold: got go=%b field=%h want 0/78", fieldGo, fieldToRwf);
      else n_pass++;
      rsta = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({cmdReady, fieldGo, wryt, rspValid, rspErr} !== 5'b0 ||
          {fieldNum, structToRwf, fieldToRwf, rspStruct, rspField} !== '0)
         $display("FAIL midop_reset_outputs: got ctrl=%b fieldNum=%h want all 0", {cmdReady, fieldGo, wryt, rspValid, rspErr}, fieldNum);
      else n_pass++;
      rsta = 1'b0;
      got_rsp = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rspValid !== 1'b0 || cmdReady !== 1'b1) got_rsp = 1'b1;
      end
      n_checks++;
      if (got_rsp) $display("FAIL midop_dropped: got response or not ready want idle");
      else n_pass++;
      do_cmd(2'd2, 4'd4, s, 64'd20, 0);
      exp_s = s; exp_s[84:73] = 12'd120;
      n_checks++;
      if (o_struct !== exp_s || o_field !== 64'd100 || o_err !== 1'b0)
         $display("FAIL midop_reissue: got %h/%h/%b want %h/64/0", o_struct, o_field, o_err, exp_s);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [1:0]   op;
      logic [3:0]   f;
      logic [127:0] s, es;
      logic [63:0]  v, ef;
      logic [31:0]  d;
      logic         ee;
      int           elat, egr, egw;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         f  = 4'($urandom_range(0, 5));
         if (i % 3 == 0) begin op = 2'd2; f = 4'($urandom_range(4, 5)); end
         s  = {$urandom, $urandom, $urandom, $urandom};
         if (f == 4'd5 && $urandom_range(0, 1) == 1) s[127:88] = 40'hFF_FFFF_F000 | 40'($urandom_range(0, 4095));
         if ($urandom_range(0, 1) == 1) begin
            d = 32'($urandom_range(0, 16383)) - 32'd8192;
            v = {{32{d[31]}}, d};
         end else begin
            v = {$urandom, $urandom};
         end
         model_op(op, f, s, v, es, ef, ee, elat, egr, egw);
         do_cmd(op, f, s, v, int'($urandom_range(0, 2)));
         n_checks++;
         if (o_struct !== es) $display("FAIL rand[%0d] struct op=%0d f=%0d: got %h want %h", i, op, f, o_struct, es);
         else n_pass++;
         n_checks++;
         if (o_field !== ef) $display("FAIL rand[%0d] field op=%0d f=%0d: got %h want %h", i, op, f, o_field, ef);
         else n_pass++;
         n_checks++;
         if (o_err !== ee) $display("FAIL rand[%0d] err op=%0d f=%0d: got %b want %b", i, op, f, o_err, ee);
         else n_pass++;
         n_checks++;
         if (o_lat != elat) $display("FAIL rand[%0d] latency op=%0d: got %0d want %0d", i, op, o_lat, elat);
         else n_pass++;
         n_checks++;
         if (o_go_rd != egr || o_go_wr != egw) $display("FAIL rand[%0d] pulses: got %0d/%0d want %0d/%0d", i, o_go_rd, o_go_wr, egr, egw);
         else n_pass++;
         n_checks++;
         if (!o_proto_ok || !o_stable_ok) $display("FAIL rand[%0d] protocol: got proto=%b stable=%b want 1/1", i, o_proto_ok, o_stable_ok);
         else n_pass++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rsta = 1'b1; cmdValid = 1'b0; cmdOp = '0; cmdField = '0;
      cmdStruct = '0; cmdValue = '0; rspReady = 1'b0;
      test_reset();
      test_rd_p1();
      test_wr_stop();
      test_add_count();
      test_add_total();
      test_illegal_backpressure();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/field_update_seq.md
# field_update_seq

Command sequencer that drives the ReadWriteField stage: accepts one field operation (read, write, or read-modify-write add) on a 128-bit hITEM binary structure and generates the `fieldGo`/`wryt`/`fieldNum`/`fieldIn` pulse sequence ReadWriteField requires. It captures `fieldOut`/`structOut` and returns the updated structure and the old field value over a valid/ready response port. It sits directly upstream of ReadWriteField and is used for page/book bookkeeping (count and total maintenance).

## Interface
- `TGT_BITS`, 64, target bus word width; structures are 2*TGT_BITS.
- `clk` in 1: single clock, rising edge.
- `rsta` in 1: reset, synchronous, active-high.
- `cmdValid` in 1: command present.
- `cmdReady` out 1: block can accept a command.
- `cmdOp` in 2: operation; 0=RD, 1=WR, 2=ADD, 3=reserved (treated as ADD on an illegal field).
- `cmdField` in 4: field selector (FLD_DATA, FLD_STOP, FLD_P1, FLD_P2, FLD_COUNT, FLD_TOTAL).
- `cmdStruct` in 2*TGT_BITS: input hITEM binary.
- `cmdValue` in TGT_BITS: WR data, or ADD signed two's-complement delta.
- `rspValid` out 1: response held until accepted.
- `rspReady` in 1: response consumer ready.
- `rspStruct` out 2*TGT_BITS: resulting structure.
- `rspField` out TGT_BITS: field value before the operation. For WR it is 0.
- `rspErr` out 1: illegal ADD field, or ADD result out of range.
- `fieldGo`, `wryt` out 1: to ReadWriteField.
- `fieldNum` out 4: to ReadWriteField.
- `structToRwf` out 2*TGT_BITS: to ReadWriteField.
- `fieldToRwf` out TGT_BITS: to ReadWriteField.
- `structFromRwf` in 2*TGT_BITS: from ReadWriteField.
- `fieldFromRwf` in TGT_BITS: from ReadWriteField.

## Operation
- States: IDLE, RD_GO, RD_CAP, WR_GO, WR_HOLD, WR_CAP, RSP.
- IDLE:
  - `cmdReady`=1.
  - On `cmdValid`, register op/field/struct/value.
  - RD, and ADD on COUNT/TOTAL, go to RD_GO.
  - WR goes to WR_GO.
  - ADD on any other field, or op 3, goes to RSP with `rspStruct`=cmdStruct, `rspField`=0, `rspErr`=1.
- RD_GO: `fieldGo`=1, `wryt`=0, `fieldNum`=reg field, `structToRwf`=reg struct.
- RD_CAP:
  - Capture `fieldFromRwf` into `rspField`.
  - RD goes to RSP with `rspStruct`=reg struct.
  - ADD computes the new value and goes to WR_GO.
- WR_GO: `fieldGo`=1, `wryt`=1, `fieldToRwf`=new value (WR: cmdValue).
- WR_HOLD: `fieldGo`=0. `fieldNum` and `fieldToRwf` stay held, because ReadWriteField applies the field in this cycle.
- WR_CAP: capture `structFromRwf` into `rspStruct`, then go to RSP.
- RSP: `rspValid`=1. On `rspReady`, go to IDLE.
- `fieldNum`, `structToRwf` and `fieldToRwf` stay stable from \*_GO through the end of the op. `fieldGo` is never high in two consecutive cycles.
- ADD arithmetic:
  - W = hCOUNT_BITS for FLD_COUNT, 40 for FLD_TOTAL.
  - sum = zero-extended old + sign-extended cmdValue, computed at TGT_BITS+1 bits.
  - Out of range means sum < 0 or sum > 2^W−1, and sets `rspErr`=1. Result handling is set under Configuration.
- FLD_P1/P2 values are full byte addresses; FLD_TOTAL is native order. ReadWriteField performs the normalization and byte reordering.

## Timing
- Command accepted at edge E0. `rspValid` is first high after:
  - E3 for RD.
  - E4 for WR.
  - E6 for ADD.
  - E1 for an illegal ADD.
- Throughput: one command in flight. `cmdReady`=0 from acceptance until RSP completes, and `cmdReady`=0 in the RSP cycle itself. The next command is accepted no earlier than the edge after the RSP handshake.
- Response backpressure: while `rspReady`=0, all rsp* outputs are held stable.
- Reset (`rsta`=1 at any edge):
  - State goes to IDLE. An in-flight command is dropped with no response.
  - All outputs are 0, including `cmdReady`=0 during reset and `fieldGo`=0.
  - `cmdReady`=1 on the first cycle after `rsta` drops.
  - ReadWriteField shares `rsta`, so a half-done write is discarded in both blocks.

## Configuration
- `FIELD_SEQ_SATURATE_EN`, when defined: an out-of-range ADD clamps to 0 (underflow) or 2^W−1 (overflow).
- When undefined: the result wraps modulo 2^W.
- `rspErr` flags out-of-range ADDs in both builds.

## Test plan
- RD FLD_P1, struct with p1=0x0034_5678, p1_hi=0x12 -> `rspField`=0x12_3456_7800, `rspStruct`=cmdStruct, `rspValid` after E3, exactly one `fieldGo` pulse with `wryt`=0.
- WR FLD_STOP value 1 on an all-zero struct -> `rspStruct` stop bit=1 and all other bits 0, `rspField`=0, response after E4, `fieldToRwf` held through WR_HOLD.
- ADD FLD_COUNT old=5, delta=+3 -> count=8, `rspField`=5, `rspErr`=0, response after E6. Delta=−7 with old=5 -> saturate build: 0, `rspErr`=1; wrap build: 2^W−2, `rspErr`=1.
- ADD FLD_TOTAL old=0xFF_FFFF_FFFE, delta=+5 -> saturate build: 0xFF_FFFF_FFFF; wrap build: 0x03; `rspErr`=1 in both.
- ADD FLD_DATA -> no `fieldGo`, `rspErr`=1, `rspStruct`=cmdStruct, response after E1. Hold `rspReady`=0 for 5 cycles -> outputs stable and `cmdReady`=0 throughout.
- Assert `rsta` during WR_HOLD of an ADD -> no response, all outputs 0. Re-issue the ADD after reset -> correct result.
